// File: rtl/squeeze_stream_pkg.sv
// -----------------------------------------------------------------------------
// squeeze_stream_pkg
// Shared definitions for the Keccak squeeze-phase output engine: state-array
// geometry, squeeze FSM states, field widths and the byte-enable generator.
// No ports (package).
// -----------------------------------------------------------------------------
package squeeze_stream_pkg;

   // Keccak-f[1600] state geometry: 5 x 5 lanes of 64 bits.
   localparam int LANE_SIZE      = 64;
   localparam int ROW_SIZE       = 5;
   localparam int COL_SIZE       = 5;
   localparam int NUM_LANES      = ROW_SIZE * COL_SIZE;
   localparam int LANE_BYTES     = LANE_SIZE / 8;
   localparam int BYTE_IDX_WIDTH = $clog2(LANE_BYTES);

   // Interface widths.
   localparam int OUT_LEN_WIDTH  = 16;
   localparam int RATE_WIDTH     = 11;
   localparam int LANE_IDX_WIDTH = 5;

   typedef enum logic [1:0] {
      SQZ_IDLE,
      SQZ_EMIT,
      SQZ_PERM_WAIT
   } sqz_state_t;

   // Byte enables for a beat: all lanes bytes when at least a full beat is
   // still owed, otherwise the low 'partial' bytes only.
   function automatic logic [LANE_BYTES-1:0] keep_mask(
      input logic                      full,
      input logic [BYTE_IDX_WIDTH-1:0] partial
   );
      if (full) begin
         return '1;
      end
      return LANE_BYTES'((9'd1 << partial) - 9'd1);
   endfunction

endpackage

// File: rtl/squeeze_stream_state_lane_select.sv
// -----------------------------------------------------------------------------
// state_lane_select
// Combinational 25:1 lane multiplexer. Lane k lives at x = k % 5, y = k / 5
// and is read as state_array[y][x], the same ordering the absorb path uses.
// Indices 25..31 return zero.
//
// Ports:
//   state_array  in   5x5x64  Keccak state
//   lane_idx     in   5       lane number k (0..24)
//   lane         out  64      selected lane
// -----------------------------------------------------------------------------
module state_lane_select
   import squeeze_stream_pkg::*;
(
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array,
   input  logic [LANE_IDX_WIDTH-1:0]                        lane_idx,
   output logic [LANE_SIZE-1:0]                             lane
);

   always_comb begin
      lane = '0;
      for (int y = 0; y < ROW_SIZE; y++) begin
         for (int x = 0; x < COL_SIZE; x++) begin
            if (lane_idx == LANE_IDX_WIDTH'(y * COL_SIZE + x)) begin
               lane = state_array[y][x];
            end
         end
      end
   end

endmodule

// File: rtl/squeeze_stream.sv
// -----------------------------------------------------------------------------
// squeeze_stream
// Squeeze-phase output engine. Streams the rate portion of the permuted
// Keccak state, one 64-bit lane per beat, on an AXI4-Stream source until
// out_len bytes have been sent, requesting a fresh permutation whenever a
// rate block is used up. The state is read in place; the core must keep it
// stable while a squeeze is running and no permutation is requested.
//
// Ports:
//   clk            in   1        clock
//   rst            in   1        asynchronous active-low reset
//   start_i        in   1        start pulse, latches rate_i/out_len_i (IDLE only)
//   rate_i         in   11       rate in bits, multiple of 64
//   out_len_i      in   16       output bytes requested
//   state_array_i  in   5x5x64   Keccak state, lane k at [k/5][k%5]
//   perm_req_o     out  1        level request for another permutation
//   perm_done_i    in   1        permutation finished pulse
//   t_data_o       out  64       stream data, little-endian bytes
//   t_keep_o       out  8        byte enables
//   t_valid_o      out  1        stream valid
//   t_last_o       out  1        final beat
//   t_ready_i      in   1        stream ready
//   done_o         out  1        pulse one cycle after the squeeze finishes
// -----------------------------------------------------------------------------
module squeeze_stream
   import squeeze_stream_pkg::*;
#(
   parameter int DWIDTH        = LANE_SIZE,
   parameter int OUT_LEN_WIDTH = squeeze_stream_pkg::OUT_LEN_WIDTH,
   parameter int RATE_WIDTH    = squeeze_stream_pkg::RATE_WIDTH
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             start_i,
   input  logic [RATE_WIDTH-1:0]                            rate_i,
   input  logic [OUT_LEN_WIDTH-1:0]                         out_len_i,
   input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
   output logic                                             perm_req_o,
   input  logic                                             perm_done_i,
   output logic [DWIDTH-1:0]                                t_data_o,
   output logic [DWIDTH/8-1:0]                              t_keep_o,
   output logic                                             t_valid_o,
   output logic                                             t_last_o,
   input  logic                                             t_ready_i,
   output logic                                             done_o
);

   sqz_state_t                state_q, state_d;
   logic [LANE_IDX_WIDTH-1:0] lane_idx_q, lane_idx_d;
   logic [LANE_IDX_WIDTH-1:0] rate_lanes_q, rate_lanes_d;
   logic [OUT_LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic                      done_q, done_d;

   logic [LANE_SIZE-1:0]      lane;
   logic [LANE_SIZE-1:0]      lane_masked;
   logic [LANE_BYTES-1:0]     keep;
   logic                      rem_full;
   logic                      rem_last;
   logic                      handshake;

   state_lane_select u_lane_select (
      .state_array (state_array_i),
      .lane_idx    (lane_idx_q),
      .lane        (lane)
   );

   assign rem_full  = (remaining_q >= OUT_LEN_WIDTH'(LANE_BYTES));
   assign rem_last  = (remaining_q <= OUT_LEN_WIDTH'(LANE_BYTES));
   assign keep      = keep_mask(rem_full, remaining_q[BYTE_IDX_WIDTH-1:0]);
   assign handshake = t_valid_o & t_ready_i;

   // Bytes beyond the requested length are zeroed so a partial last beat
   // never leaks state material past the digest.
   always_comb begin
      lane_masked = '0;
      for (int b = 0; b < LANE_BYTES; b++) begin
         if (keep[b]) begin
            lane_masked[b*8 +: 8] = lane[b*8 +: 8];
         end
      end
   end

   // NOTE: every signal driven here gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      lane_idx_d   = lane_idx_q;
      rate_lanes_d = rate_lanes_q;
      remaining_d  = remaining_q;
      done_d       = 1'b0;
      perm_req_o   = 1'b0;
      t_valid_o    = 1'b0;
      t_data_o     = '0;
      t_keep_o     = '0;
      t_last_o     = 1'b0;

      case (state_q)
         SQZ_IDLE: begin
            if (start_i) begin
               rate_lanes_d = LANE_IDX_WIDTH'(rate_i >> 6);
               remaining_d  = out_len_i;
               lane_idx_d   = '0;
               if (out_len_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = SQZ_EMIT;
               end
            end
         end

         SQZ_EMIT: begin
            t_valid_o = 1'b1;
            t_data_o  = DWIDTH'(lane_masked);
            t_keep_o  = (DWIDTH/8)'(keep);
            t_last_o  = rem_last;
            if (handshake) begin
               // Saturating decrement: a partial beat consumes what is left.
               remaining_d = rem_full ? remaining_q - OUT_LEN_WIDTH'(LANE_BYTES) : '0;
               if (rem_last) begin
                  state_d = SQZ_IDLE;
                  done_d  = 1'b1;
               end else if (lane_idx_q == rate_lanes_q - LANE_IDX_WIDTH'(1)) begin
                  lane_idx_d = '0;
                  state_d    = SQZ_PERM_WAIT;
               end else begin
                  lane_idx_d = lane_idx_q + LANE_IDX_WIDTH'(1);
               end
            end
         end

         SQZ_PERM_WAIT: begin
            perm_req_o = 1'b1;
            if (perm_done_i) begin
               state_d = SQZ_EMIT;
            end
         end

         default: begin
            state_d = SQZ_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SQZ_IDLE;
         lane_idx_q   <= '0;
         rate_lanes_q <= '0;
         remaining_q  <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         lane_idx_q   <= lane_idx_d;
         rate_lanes_q <= rate_lanes_d;
         remaining_q  <= remaining_d;
         done_q       <= done_d;
      end
   end

   assign done_o = done_q;

endmodule

// File: tb/tb_squeeze_stream.sv
// -----------------------------------------------------------------------------
// tb_squeeze_stream
// Directed bench for squeeze_stream: SHA3-256, SHA3-224 partial last beat,
// SHAKE128 across a permutation (with steady and random ready), zero-length
// request, and reset in the middle of a permutation wait.
// -----------------------------------------------------------------------------
module tb_squeeze_stream;
   import squeeze_stream_pkg::*;

   logic                                             clk = 1'b0;
   logic                                             rst;
   logic                                             start_i;
   logic [RATE_WIDTH-1:0]                            rate_i;
   logic [OUT_LEN_WIDTH-1:0]                         out_len_i;
   logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array;
   logic                                             perm_req_o;
   logic                                             perm_done_i;
   logic [63:0]                                      t_data_o;
   logic [7:0]                                       t_keep_o;
   logic                                             t_valid_o;
   logic                                             t_last_o;
   logic                                             t_ready_i;
   logic                                             done_o;

   squeeze_stream dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .rate_i        (rate_i),
      .out_len_i     (out_len_i),
      .state_array_i (state_array),
      .perm_req_o    (perm_req_o),
      .perm_done_i   (perm_done_i),
      .t_data_o      (t_data_o),
      .t_keep_o      (t_keep_o),
      .t_valid_o     (t_valid_o),
      .t_last_o      (t_last_o),
      .t_ready_i     (t_ready_i),
      .done_o        (done_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Observations collected by run_stream.
   logic [63:0] data_q[$];
   logic [7:0]  keep_q[$];
   bit          last_q[$];
   int          first_valid, last_hs, done_cyc, done_pulses;
   int          perm_high, perm_reqs, stall_errs, valid_in_perm;
   bit          timed_out;

   function automatic logic [63:0] lane_val(input int v);
      return {8{8'(v)}};
   endfunction

   // Lane k = y*5+x holds byte value base+k in every byte.
   task automatic fill_state(input int base);
      for (int y = 0; y < ROW_SIZE; y++) begin
         for (int x = 0; x < COL_SIZE; x++) begin
            state_array[y][x] = lane_val(base + y * COL_SIZE + x);
         end
      end
   endtask

   task automatic do_start(input int rate, input int len);
      @(negedge clk);
      start_i   = 1'b1;
      rate_i    = RATE_WIDTH'(rate);
      out_len_i = OUT_LEN_WIDTH'(len);
   endtask

   // Clocks the stream after a start, acting as sink and as the permutation
   // core (perm_done 5 cycles into each request, loading state base new_base).
   task automatic run_stream(input int budget, input bit rand_ready, input int new_base);
      bit          prev_stall = 1'b0;
      bit          prev_req   = 1'b0;
      int          req_run    = 0;
      logic [63:0] pd;
      logic [7:0]  pk;
      logic        pl;
      data_q.delete();
      keep_q.delete();
      last_q.delete();
      first_valid = -1; last_hs = -1; done_cyc = -1; done_pulses = 0;
      perm_high = 0; perm_reqs = 0; stall_errs = 0; valid_in_perm = 0;
      timed_out = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         start_i     = 1'b0;
         t_ready_i   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         perm_done_i = 1'b0;
         if (perm_req_o) begin
            perm_high++;
            if (!prev_req) perm_reqs++;
            if (t_valid_o) valid_in_perm++;
            req_run++;
            if (req_run == 5) begin
               perm_done_i = 1'b1;
               fill_state(new_base);
               req_run = 0;
            end
         end
         prev_req = perm_req_o;
         if (prev_stall && (!t_valid_o || t_data_o !== pd || t_keep_o !== pk || t_last_o !== pl))
            stall_errs++;
         prev_stall = t_valid_o && !t_ready_i;
         pd = t_data_o; pk = t_keep_o; pl = t_last_o;
         if (t_valid_o && first_valid < 0) first_valid = cyc;
         if (t_valid_o && t_ready_i) begin
            data_q.push_back(t_data_o);
            keep_q.push_back(t_keep_o);
            last_q.push_back(t_last_o);
            last_hs = cyc;
         end
         if (done_o) begin
            done_pulses++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      end
      if (done_cyc < 0) timed_out = 1'b1;
      perm_done_i = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({perm_req_o, t_valid_o, t_last_o, t_keep_o, t_data_o, done_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got req=%b valid=%b last=%b keep=%h data=%h done=%b, want all 0",
                  perm_req_o, t_valid_o, t_last_o, t_keep_o, t_data_o, done_o);
      end
   endtask

   task automatic test_sha3_256();
      logic [63:0] exp_d;
      fill_state(1);
      do_start(1088, 32);
      run_stream(100, 1'b0, 0);
      n_checks++;
      if (timed_out !== 1'b0) begin n_fail++; $display("FAIL sha256_timeout: done_o never seen"); end
      n_checks++;
      if (data_q.size() !== 4) begin n_fail++; $display("FAIL sha256_beats: got %0d, want 4", data_q.size()); end
      for (int i = 0; i < int'(data_q.size()) && i < 4; i++) begin
         exp_d = lane_val(i + 1);
         n_checks++;
         if (data_q[i] !== exp_d || keep_q[i] !== 8'hFF || last_q[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL sha256_beat%0d: got data=%h keep=%h last=%b, want data=%h keep=ff last=%b",
                     i, data_q[i], keep_q[i], last_q[i], exp_d, (i == 3));
         end
      end
      n_checks++;
      if (first_valid !== 0) begin n_fail++; $display("FAIL sha256_latency: first valid cycle %0d, want 0", first_valid); end
      n_checks++;
      if (done_cyc !== last_hs + 1 || done_pulses !== 1) begin
         n_fail++;
         $display("FAIL sha256_done: done at %0d (%0d pulses), want %0d (1 pulse)", done_cyc, done_pulses, last_hs + 1);
      end
      n_checks++;
      if (perm_high !== 0) begin n_fail++; $display("FAIL sha256_perm_req: high %0d cycles, want 0", perm_high); end
   endtask

   task automatic test_sha3_224_partial();
      logic [63:0] exp_d;
      logic [7:0]  exp_k;
      fill_state(1);
      do_start(1152, 28);
      run_stream(100, 1'b0, 0);
      n_checks++;
      if (data_q.size() !== 4 || timed_out) begin
         n_fail++;
         $display("FAIL sha224_beats: got %0d (timeout=%b), want 4", data_q.size(), timed_out);
      end
      for (int i = 0; i < int'(data_q.size()) && i < 4; i++) begin
         exp_d = (i == 3) ? 64'h0000_0000_0404_0404 : lane_val(i + 1);
         exp_k = (i == 3) ? 8'h0F : 8'hFF;
         n_checks++;
         if (data_q[i] !== exp_d || keep_q[i] !== exp_k || last_q[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL sha224_beat%0d: got data=%h keep=%h last=%b, want data=%h keep=%h last=%b",
                     i, data_q[i], keep_q[i], last_q[i], exp_d, exp_k, (i == 3));
         end
      end
      n_checks++;
      if (done_cyc !== last_hs + 1) begin n_fail++; $display("FAIL sha224_done: done at %0d, want %0d", done_cyc, last_hs + 1); end
   endtask

   task automatic test_shake128(input bit rand_ready);
      logic [63:0] exp_d;
      fill_state(1);
      do_start(1344, 200);
      run_stream(600, rand_ready, 8'h80);
      n_checks++;
      if (data_q.size() !== 25 || timed_out) begin
         n_fail++;
         $display("FAIL shake_beats(rand=%b): got %0d (timeout=%b), want 25", rand_ready, data_q.size(), timed_out);
      end
      for (int i = 0; i < int'(data_q.size()) && i < 25; i++) begin
         exp_d = (i < 21) ? lane_val(i + 1) : lane_val(8'h80 + i - 21);
         n_checks++;
         if (data_q[i] !== exp_d || keep_q[i] !== 8'hFF || last_q[i] !== (i == 24)) begin
            n_fail++;
            $display("FAIL shake_beat%0d(rand=%b): got data=%h keep=%h last=%b, want data=%h keep=ff last=%b",
                     i, rand_ready, data_q[i], keep_q[i], last_q[i], exp_d, (i == 24));
         end
      end
      n_checks++;
      if (perm_reqs !== 1 || perm_high !== 5 || valid_in_perm !== 0) begin
         n_fail++;
         $display("FAIL shake_perm(rand=%b): got %0d requests, %0d high cycles, %0d valid while waiting; want 1, 5, 0",
                  rand_ready, perm_reqs, perm_high, valid_in_perm);
      end
      n_checks++;
      if (stall_errs !== 0) begin n_fail++; $display("FAIL shake_stall(rand=%b): %0d unstable stall cycles, want 0", rand_ready, stall_errs); end
      n_checks++;
      if (done_cyc !== last_hs + 1 || done_pulses !== 1) begin
         n_fail++;
         $display("FAIL shake_done(rand=%b): done at %0d (%0d pulses), want %0d (1 pulse)", rand_ready, done_cyc, done_pulses, last_hs + 1);
      end
   endtask

   task automatic test_zero_length();
      fill_state(1);
      do_start(1088, 0);
      run_stream(20, 1'b0, 0);
      n_checks++;
      if (first_valid !== -1 || data_q.size() !== 0) begin
         n_fail++;
         $display("FAIL zero_len_valid: valid first at %0d with %0d beats, want never", first_valid, data_q.size());
      end
      n_checks++;
      if (done_cyc !== 0 || done_pulses !== 1) begin
         n_fail++;
         $display("FAIL zero_len_done: done at %0d (%0d pulses), want 0 (1 pulse)", done_cyc, done_pulses);
      end
   endtask

   task automatic test_reset_in_perm_wait();
      bit          saw_req = 1'b0;
      logic [63:0] exp_d;
      fill_state(1);
      do_start(1344, 200);
      for (int cyc = 0; cyc < 60 && !saw_req; cyc++) begin
         @(negedge clk);
         start_i   = 1'b0;
         t_ready_i = 1'b1;
         saw_req   = perm_req_o;
      end
      n_checks++;
      if (saw_req !== 1'b1) begin n_fail++; $display("FAIL rst_perm_reached: perm_req_o=%b, want 1", saw_req); end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({perm_req_o, t_valid_o, t_last_o, t_keep_o, t_data_o, done_o} !== '0) begin
         n_fail++;
         $display("FAIL rst_perm_outputs: got req=%b valid=%b last=%b keep=%h data=%h done=%b, want all 0",
                  perm_req_o, t_valid_o, t_last_o, t_keep_o, t_data_o, done_o);
      end
      @(negedge clk);
      rst = 1'b1;
      do_start(576, 64);
      run_stream(100, 1'b0, 0);
      n_checks++;
      if (data_q.size() !== 8 || timed_out) begin
         n_fail++;
         $display("FAIL sha512_beats: got %0d (timeout=%b), want 8", data_q.size(), timed_out);
      end
      for (int i = 0; i < int'(data_q.size()) && i < 8; i++) begin
         exp_d = lane_val(i + 1);
         n_checks++;
         if (data_q[i] !== exp_d || keep_q[i] !== 8'hFF || last_q[i] !== (i == 7)) begin
            n_fail++;
            $display("FAIL sha512_beat%0d: got data=%h keep=%h last=%b, want data=%h keep=ff last=%b",
                     i, data_q[i], keep_q[i], last_q[i], exp_d, (i == 7));
         end
      end
      n_checks++;
      if (perm_high !== 0) begin n_fail++; $display("FAIL sha512_perm_req: high %0d cycles, want 0", perm_high); end
   endtask

   initial begin
      rst         = 1'b0;
      start_i     = 1'b0;
      rate_i      = '0;
      out_len_i   = '0;
      perm_done_i = 1'b0;
      t_ready_i   = 1'b0;
      fill_state(1);
      #1;
      test_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      test_sha3_256();
      test_sha3_224_partial();
      test_shake128(1'b0);
      test_shake128(1'b1);
      test_zero_length();
      test_reset_in_perm_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/squeeze_stream.md
Name: squeeze_stream

Overview:
Squeeze-phase output engine for the Keccak datapath and the transmit counterpart of the absorb path.
- Reads the rate portion of the permuted 1600-bit state one 64-bit lane per beat.
- Emits the digest/XOF bytes on an AXI4-Stream source.
- When a rate block is exhausted and more output is needed, requests a further permutation from the core.

Parameters:
DWIDTH, 64, output beat width in bits; fixed to LANE_SIZE, one lane per beat
OUT_LEN_WIDTH, 16, width of the requested output length in bytes
RATE_WIDTH, 11, width of the rate input in bits (max 1344)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; latches rate_i and out_len_i; ignored unless IDLE
rate_i  in  RATE_WIDTH  rate in bits; always a multiple of 64
out_len_i  in  OUT_LEN_WIDTH  total output bytes requested
state_array_i  in  [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]  current Keccak state; core holds it stable except during a permutation
perm_req_o  out  1  level request for a new permutation
perm_done_i  in  1  one-cycle pulse: permutation finished, state_array_i updated
t_data_o  out  DWIDTH  AXI4-Stream data, little-endian bytes
t_keep_o  out  DWIDTH/8  byte enables
t_valid_o  out  1  AXI4-Stream valid
t_last_o  out  1  final beat of the output
t_ready_i  in  1  AXI4-Stream ready
done_o  out  1  one-cycle pulse after squeeze completion

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; lane_idx=0, remaining=0, rate_lanes=0.
  - Outputs: perm_req_o=0, t_valid_o=0, t_last_o=0, t_keep_o=0, t_data_o=0, done_o=0.
  - Reset mid-operation abandons the stream with no t_last.
- Lane k maps to x=k%5, y=k/5, indexed as state_array_i[y][x], consistent with the absorb path.
- IDLE:
  - On start_i: rate_lanes<=rate_i>>6, remaining<=out_len_i, lane_idx<=0.
  - If out_len_i==0: stay IDLE and pulse done_o on the next cycle. Otherwise go to EMIT.
- EMIT:
  - t_valid_o=1; t_data_o=lane[lane_idx] with bytes at and above remaining forced to 0.
  - t_keep_o = 8'hFF if remaining>=8, else (1<<remaining)-1.
  - t_last_o = (remaining<=8).
  - On handshake (t_valid_o && t_ready_i): remaining <= remaining - min(8, remaining).
    - If t_last_o: go to IDLE and pulse done_o the following cycle.
    - Else if lane_idx==rate_lanes-1: lane_idx<=0 and go to PERM_WAIT.
    - Else: lane_idx<=lane_idx+1.
  - No handshake: all outputs hold stable. t_valid_o never drops before the handshake.
- PERM_WAIT:
  - perm_req_o=1, t_valid_o=0.
  - On perm_done_i: perm_req_o deasserts, go to EMIT; the next beat reads lane 0 of the new state.
- Latency: the first beat is valid the cycle after start_i. Sustained throughput is 1 beat/cycle within a block.
- perm_done_i outside PERM_WAIT is ignored. start_i outside IDLE is ignored.
- remaining never underflows. A final partial beat (SHA3-224: 28 bytes) asserts keep 0x0F.
- No internal state copy; the core must not modify state_array_i while perm_req_o=0 and the FSM is not IDLE.

Decomposition:
- keccak_pkg additions: squeeze FSM enum typedef (SQZ_IDLE, SQZ_EMIT, SQZ_PERM_WAIT), OUT_LEN_WIDTH, LANE_IDX_WIDTH=5, and the keep-generation function.
- One natural sub-module: state_lane_select, a combinational 25:1 lane mux from a lane index to a 64-bit lane, reusable by the absorb path.

Test Plan:
- Lane k filled with byte value k+1 throughout. SHA3-256 (rate 1088), out_len 32, t_ready_i=1:
  - 4 beats, data 0x0101..01, 0x0202..02, 0x0303..03, 0x0404..04; keep 0xFF.
  - t_last_o on beat 4; perm_req_o never asserted; done_o one cycle after beat 4.
- SHA3-224 (rate 1152), out_len 28: 4 beats; beat 4 keep=0x0F, data=0x0000_0000_0404_0404, t_last_o=1.
- SHAKE128 (rate 1344), out_len 200, perm_done_i 5 cycles after perm_req_o, with new state lane k = k+0x80:
  - 21 beats, then perm_req_o high for exactly 5 cycles with t_valid_o=0.
  - 4 more beats 0x80.., 0x81.., 0x82.., 0x83..; last on beat 25.
- Same SHAKE128 run with random 50% t_ready_i: data, keep and last stable during stalls; sequence identical to the previous scenario.
- out_len 0: t_valid_o never rises; done_o pulses one cycle after start_i.
- rst low during PERM_WAIT: all outputs 0 immediately. A subsequent SHA3-512 (rate 576) start with out_len 64 emits 8 beats from lane 0, last on beat 8, no perm_req_o.
